// File: rtl/cla_seq_adder.sv
// Multi-cycle carry-lookahead adder/subtractor: resolves one GROUP-bit lookahead group per
// clock, least-significant group first, with the group carry held in a register between cycles.
module cla_seq_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned GROUP = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int unsigned NumGroups = WIDTH / GROUP;
   localparam int unsigned IdxW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumGroups - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] work_q;
   logic             carry_q;
   logic [IdxW-1:0]  idx_q;

   logic [GROUP-1:0] g;
   logic [GROUP-1:0] p;
   logic [GROUP-1:0] sum;
   logic [GROUP:0]   c;
   logic             term;
   logic [WIDTH-1:0] work_next;

   // Operand registers shift right each cycle, so the active group is always the low slice.
   always_comb begin
      g    = a_q[GROUP-1:0] & b_q[GROUP-1:0];
      p    = a_q[GROUP-1:0] | b_q[GROUP-1:0];
      c    = '0;
      term = 1'b0;
      c[0] = carry_q;
      for (int j = 0; j < int'(GROUP); j++) begin
         // Flat sum of products: carry register term plus one term per generate bit.
         term = carry_q;
         for (int k = 0; k <= j; k++) begin
            term = term & p[k];
         end
         c[j+1] = term;
         for (int i = 0; i <= j; i++) begin
            term = g[i];
            for (int k = i + 1; k <= j; k++) begin
               term = term & p[k];
            end
            c[j+1] = c[j+1] | term;
         end
      end
      sum = a_q[GROUP-1:0] ^ b_q[GROUP-1:0] ^ c[GROUP-1:0];
   end

   // Work register fills from the top; after the last group, group 0 sits in the low bits.
   generate
      if (GROUP == WIDTH) begin : g_single
         assign work_next = sum;
      end else begin : g_multi
         assign work_next = {sum, work_q[WIDTH-1:GROUP]};
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         s       <= '0;
         co      <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b ^ {WIDTH{sub}};
                  carry_q <= ci ^ sub;
                  idx_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= StRun;
               end else begin
                  state_q <= StIdle;
               end
            end
            StRun: begin
               a_q     <= a_q >> GROUP;
               b_q     <= b_q >> GROUP;
               carry_q <= c[GROUP];
               work_q  <= work_next;
               if (idx_q == LastIdx) begin
                  s       <= work_next;
                  co      <= c[GROUP];
                  ovf     <= c[GROUP] ^ c[GROUP-1];
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StDone;
               end else begin
                  idx_q <= idx_q + IdxW'(1);
               end
            end
            default: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
